oka_32bit_seq_ctrl: RTL and testbench

- Area-reduced 32x32 carry-less (GF(2)[x]) multiplier sequencer producing a 63-bit product.
- Time-multiplexes one shared 16x16 carry-less multiplier core (the team's 16-bit OKA core, 31-bit product) over three issue cycles, using Karatsuba over GF(2): z0 = al*bl, z1 = (al^ah)*(bl^bh), z2 = ah*bh.
- Owns operand capture, the issue FSM, result capture and the final XOR combine.
- Valid/ready on input and output; drop-in sequential replacement for the fully parallel 32-bit OKA multiplier.

---
 rtl/oka_32bit_seq_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_oka_32bit_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oka_32bit_seq_ctrl.sv
// oka_32bit_seq_ctrl
// Area-reduced 32x32 carry-less (GF(2)[x]) multiplier producing a 63-bit
// product. A single shared 16x16 carry-less core is time-multiplexed over
// three issue cycles using Karatsuba over GF(2):
//   z0 = al*bl, z1 = (al^ah)*(bl^bh), z2 = ah*bh
//   y  = z0 ^ ((z0^z1^z2) << 16) ^ (z2 << 32)
// One transaction is in flight at a time. Latency is fixed: out_valid rises
// 4+MUL_LAT cycles after the accept edge.
//
// Parameters:
//   MUL_LAT   register stages on the shared multiplier output (0..2)
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   in_valid  operand pair valid
//   in_ready  block can accept operands
//   a, b      32-bit operands (bit i = coefficient of x^i)
//   out_valid product valid
//   out_ready consumer accepts product
//   y         63-bit carry-less product
//   busy      high whenever the FSM is not in IDLE
module oka_32bit_seq_ctrl #(
  parameter int MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [62:0] y,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, I0, I1, I2, WAIT, DONE} state_t;

  localparam bit         HAS_WAIT  = (MUL_LAT > 0);
  localparam logic [1:0] WAIT_LAST = (MUL_LAT > 0) ? 2'(MUL_LAT - 1) : 2'd0;

  state_t      state;
  state_t      next_state;

  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [30:0] z0;
  logic [30:0] z1;
  logic [62:0] y_q;
  logic [1:0]  wait_cnt;
  logic        out_valid_q;

  logic        accept;
  logic        handshake;

  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [30:0] mul_p;
  logic        issue_vld;
  logic [1:0]  issue_tag;

  logic        cap_vld;
  logic [1:0]  cap_tag;
  logic [30:0] cap_p;
  logic [62:0] y_next;

  // Shared 16x16 carry-less core.
  function automatic logic [30:0] clmul16(input logic [15:0] x, input logic [15:0] m);
    logic [30:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) acc = acc ^ ({15'b0, x} << i);
    end
    return acc;
  endfunction

  // out_valid is a registered flag set one cycle after entering DONE, which
  // lands exactly one edge after the z2 capture has loaded y.
  assign handshake = out_valid_q & out_ready;
  assign in_ready  = (state == IDLE) | ((state == DONE) & handshake);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign busy      = (state != IDLE);

  // Operand selection for the shared core; the tag travels with the product
  // so the capture stage knows which Karatsuba term arrived.
  always_comb begin
    mul_a     = '0;
    mul_b     = '0;
    issue_vld = 1'b0;
    issue_tag = 2'd0;
    case (state)
      I0: begin
        mul_a     = a_q[15:0];
        mul_b     = b_q[15:0];
        issue_vld = 1'b1;
        issue_tag = 2'd0;
      end
      I1: begin
        mul_a     = a_q[15:0] ^ a_q[31:16];
        mul_b     = b_q[15:0] ^ b_q[31:16];
        issue_vld = 1'b1;
        issue_tag = 2'd1;
      end
      I2: begin
        mul_a     = a_q[31:16];
        mul_b     = b_q[31:16];
        issue_vld = 1'b1;
        issue_tag = 2'd2;
      end
      default: ;
    endcase
  end

  assign mul_p = clmul16(mul_a, mul_b);

  // Optional output pipeline of the shared core.
  generate
    if (MUL_LAT == 0) begin : g_no_pipe
      assign cap_vld = issue_vld;
      assign cap_tag = issue_tag;
      assign cap_p   = mul_p;
    end else begin : g_pipe
      logic [MUL_LAT-1:0] vld_pipe;
      logic [1:0]         tag_pipe  [MUL_LAT];
      logic [30:0]        prod_pipe [MUL_LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_pipe <= '0;
          for (int i = 0; i < MUL_LAT; i++) begin
            tag_pipe[i]  <= 2'd0;
            prod_pipe[i] <= '0;
          end
        end else begin
          vld_pipe[0]  <= issue_vld;
          tag_pipe[0]  <= issue_tag;
          prod_pipe[0] <= mul_p;
          for (int i = 1; i < MUL_LAT; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            tag_pipe[i]  <= tag_pipe[i-1];
            prod_pipe[i] <= prod_pipe[i-1];
          end
        end
      end

      assign cap_vld = vld_pipe[MUL_LAT-1];
      assign cap_tag = tag_pipe[MUL_LAT-1];
      assign cap_p   = prod_pipe[MUL_LAT-1];
    end
  endgenerate

  // z2 is never stored: it feeds the combine directly on the edge it arrives.
  assign y_next = {32'b0, z0}
                ^ {16'b0, (z0 ^ z1 ^ cap_p), 16'b0}
                ^ {cap_p, 32'b0};

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = I0;
      I0:   next_state = I1;
      I1:   next_state = I2;
      I2:   next_state = HAS_WAIT ? WAIT : DONE;
      WAIT: if (wait_cnt == WAIT_LAST) next_state = DONE;
      DONE: begin
        if (handshake) next_state = accept ? I0 : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State, operand latches, term capture and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      z0          <= '0;
      z1          <= '0;
      y_q         <= '0;
      wait_cnt    <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      state <= next_state;

      if (accept) begin
        a_q <= a;
        b_q <= b;
      end

      if (state == I2)        wait_cnt <= 2'd0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 2'd1;

      if (cap_vld) begin
        case (cap_tag)
          2'd0:    z0  <= cap_p;
          2'd1:    z1  <= cap_p;
          2'd2:    y_q <= y_next;
          default: ;
        endcase
      end

      if (handshake)          out_valid_q <= 1'b0;
      else if (state == DONE) out_valid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_oka_32bit_seq_ctrl.sv
// tb_oka_32bit_seq_ctrl
// Scoreboard bench for oka_32bit_seq_ctrl. The driver pushes the reference
// product (plain shift-and-xor polynomial multiply) when an operand pair is
// accepted; an independent monitor pops and compares on every output
// handshake, and also checks latency, hold stability and busy.
module tb_oka_32bit_seq_ctrl;

  parameter int LAT = 0;

  typedef struct {
    logic [62:0] prod;
    int          acc_edge;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [62:0] y;
  logic        busy;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          rand_ready = 0;

  bit          prev_ov = 0;
  bit          prev_hold = 0;
  logic [62:0] prev_y = '0;

  oka_32bit_seq_ctrl #(.MUL_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  // 10 ns clock; inputs change on negedge, samples at negedge+2/+3.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Reference product: polynomial multiply over GF(2).
  function automatic logic [62:0] clmulRef(input logic [31:0] x, input logic [31:0] m);
    logic [62:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) acc = acc ^ ({31'b0, x} << i);
    end
    return acc;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present an operand pair and hold it until accepted; push the expected
  // product on the cycle the accept edge will happen.
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv);
    int  waited;
    bit  done;
    exp_t e;
    waited = 0;
    done   = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a = av;
    b = bv;
    while (!done) begin
      #3;
      if (in_ready && !rst) begin
        e.prod     = clmulRef(av, bv);
        e.acc_edge = cyc + 1;
        sb.push_back(e);
        done = 1;
      end else begin
        waited++;
        if (waited > 64) begin
          checks++;
          errors++;
          $display("[TB] FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", waited);
          done = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("rst_y",         {1'b0, y},          64'd0);
    checkOutput("rst_busy",      {63'b0, busy},      64'd0);
    checkOutput("rst_in_ready",  {63'b0, in_ready},  64'd1);
  endtask

  // Random backpressure during the random phase.
  always @(negedge clk) begin
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compares outputs against the scoreboard.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_ov   = 0;
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        checkOutput("hold_valid", {63'b0, out_valid}, 64'd1);
        checkOutput("hold_y", {1'b0, y}, {1'b0, prev_y});
      end
      checkOutput("busy", {63'b0, busy}, {63'b0, (sb.size() != 0)});
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL spurious_valid: got out_valid=1, expected 0 (nothing pending)");
        end else begin
          checkOutput("latency", 64'(cyc - sb[0].acc_edge), 64'(4 + LAT));
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got y=0x%0h, expected no product", y);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("product", {1'b0, y}, {1'b0, e.prod});
        end
      end
      prev_ov   = out_valid;
      prev_hold = out_valid && !out_ready;
      prev_y    = y;
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          waited;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    doReset();

    // Directed values.
    applyStimulus(32'h0000_0003, 32'h0000_0003); idleCycles(8);
    applyStimulus(32'h0001_0000, 32'h0000_0001); idleCycles(8);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF); idleCycles(8);
    applyStimulus(32'h8000_0000, 32'h8000_0000); idleCycles(8);
    applyStimulus(32'h0000_0000, 32'hDEAD_BEEF); idleCycles(8);

    // Backpressure: output held, new operands ignored.
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(32'hA5A5_1234, 32'h0F0F_8001);
    repeat (4 + LAT + 10) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = $urandom;
      b = $urandom;
      #3;
      checkOutput("bp_in_ready", {63'b0, in_ready}, 64'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idleCycles(4);

    // Back-to-back with in_valid held high.
    repeat (3) applyStimulus($urandom, $urandom);
    idleCycles(10);

    // Reset while in I1, then a clean transaction.
    applyStimulus(32'hCAFE_F00D, 32'h1357_9BDF);
    @(negedge clk);
    doReset();
    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0);
    idleCycles(10);

    // Random pairs with random gaps and backpressure.
    rand_ready = 1;
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 7))
        0:       begin ra = 32'h0;        rb = $urandom; end
        1:       begin ra = 32'hFFFF_FFFF; rb = $urandom; end
        2:       begin ra = $urandom;      rb = 32'h8000_0001; end
        default: begin ra = $urandom;      rb = $urandom; end
      endcase
      idleCycles($urandom_range(0, 2));
      applyStimulus(ra, rb);
    end
    @(negedge clk);
    in_valid   = 1'b0;
    rand_ready = 0;
    out_ready  = 1'b1;

    waited = 0;
    while (sb.size() != 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d products pending, expected 0", sb.size());
    end
    idleCycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
